// File: rtl/sprite_line_sched_pkg.sv
// Shared types for the sprite line scheduler: object entry layout, size decode, FSM states.
// Optional build macro SPR_SKIP_BLANK_EN is consumed by the top module.
package sprite_pkg;

    localparam int DRAW_GAP_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_CHK,
        S_FETCH,
        S_DRAW,
        S_NEXT
    } state_t;

    typedef struct packed {
        logic [5:0]  rsv_63_58;
        logic [9:0]  x;
        logic [5:0]  rsv_47_42;
        logic        flipy;
        logic        flipx;
        logic        prio;
        logic [6:0]  color;
        logic [15:0] code;
        logic        rsv_15;
        logic [1:0]  wcode;
        logic [1:0]  hcode;
        logic [1:0]  rsv_10_9;
        logic [8:0]  y;
    } obj_entry_t;

    // height in pixels (16..128), width in 16-px columns (1..8)
    typedef struct packed {
        logic [7:0] height;
        logic [3:0] width;
    } spr_size_t;

    function automatic spr_size_t size_decode(input logic [1:0] hcode, input logic [1:0] wcode);
        spr_size_t s;
        s.height = 8'd16 << hcode;
        s.width  = 4'd1 << wcode;
        return s;
    endfunction

endpackage

// File: rtl/sprite_line_sched_row_fetch.sv
// One 64-bit planar row fetch per start: tile/row address math, req/ack handshake,
// and per-plane bit reversal for horizontally flipped sprites.
module sprite_row_fetch
    import sprite_pkg::*;
#(
    parameter int ROM_AW = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  obj_entry_t        entry,
    input  logic [6:0]        rel,
    input  logic [2:0]        col,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [63:0]       rom_data,
    output logic              done,
    output logic [63:0]       row_data
);

    function automatic logic [63:0] rev_planes(input logic [63:0] d);
        logic [63:0] r;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 16; b++) begin
                r[p*16+b] = d[p*16+15-b];
            end
        end
        return r;
    endfunction

    spr_size_t   size;
    logic [6:0]  erel;
    logic [2:0]  c;
    logic [15:0] tile;
    logic [19:0] addr_full;
    logic        req_q;
    logic        unused_fields;

    assign size = size_decode(entry.hcode, entry.wcode);
    // Heights are multiples of 16, so mirroring rel also inverts the row nibble.
    assign erel      = entry.flipy ? (size.height[6:0] - 7'd1 - rel) : rel;
    assign c         = entry.flipx ? (size.width[2:0] - 3'd1 - col) : col;
    assign tile      = entry.code + {10'd0, c, 3'd0} + {13'd0, erel[6:4]};
    assign addr_full = {tile, erel[3:0]};

    // An abort kills the request combinationally so a racing ack is never taken.
    assign rom_req = req_q && !abort;
    assign done    = req_q && rom_ack && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= 1'b0;
            rom_addr <= '0;
            row_data <= '0;
        end else if (abort) begin
            req_q <= 1'b0;
        end else if (done) begin
            req_q    <= 1'b0;
            row_data <= entry.flipx ? rev_planes(rom_data) : rom_data;
        end else if (start && !req_q) begin
            req_q    <= 1'b1;
            rom_addr <= ROM_AW'(addr_full);
        end
    end

    assign unused_fields = ^{entry.y, entry.color, entry.prio, entry.x, entry.rsv_63_58,
                             entry.rsv_47_42, entry.rsv_15, entry.rsv_10_9,
                             size.height[7], size.width[3]};

endmodule

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: scans the object list, fetches rows of hitting sprites and
// issues paced draw pulses to the line buffer. Define SPR_SKIP_BLANK_EN to drop all-zero rows.
// Handshakes: rom_req rises and holds with a stable rom_addr until a one-cycle rom_ack
// (data in the same cycle); obj_data is valid one cycle after obj_addr; we is a one-cycle strobe.
module sprite_line_sched
    import sprite_pkg::*;
#(
    parameter int OBJ_AW   = 8,
    parameter int ROM_AW   = 20,
    parameter int DRAW_GAP = DRAW_GAP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [8:0]        v_line,
    input  logic [OBJ_AW:0]   obj_count,
    output logic [OBJ_AW-1:0] obj_addr,
    input  logic [63:0]       obj_data,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [63:0]       rom_data,
    output logic [63:0]       bits,
    output logic [6:0]        color,
    output logic              prio,
    output logic [9:0]        pos,
    output logic              we,
    output logic              busy,
    output logic              overflow
);

    localparam int GW = $clog2(DRAW_GAP + 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(DRAW_GAP - 1);

    state_t          state_q, state_d;
    logic [OBJ_AW:0] idx_q, cnt_q, idx_inc;
    logic [8:0]      vline_q, rel;
    obj_entry_t      entry_q;
    logic [2:0]      col_q;
    logic [GW-1:0]   gap_q;
    spr_size_t       size;
    logic [63:0]     row_data;
    logic            hit, last_col, blank, abort;
    logic            fetch_start, fetch_done, draw_adv, draw_fire;

    assign size     = size_decode(entry_q.hcode, entry_q.wcode);
    assign rel      = vline_q - entry_q.y;
    assign hit      = rel < {1'b0, size.height};
    assign last_col = ({1'b0, col_q} + 4'd1) >= size.width;
    assign idx_inc  = idx_q + 1'b1;
    assign obj_addr = idx_q[OBJ_AW-1:0];
    assign abort    = line_start && (state_q != S_IDLE);

`ifdef SPR_SKIP_BLANK_EN
    assign blank = (row_data == 64'd0);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RD:    state_d = S_LAT;
            S_LAT:   state_d = S_CHK;
            S_CHK:   state_d = hit ? S_FETCH : S_NEXT;
            S_FETCH: if (fetch_done) state_d = S_DRAW;
            S_DRAW:  if (draw_adv) state_d = last_col ? S_NEXT : S_FETCH;
            S_NEXT:  state_d = (idx_inc == cnt_q) ? S_IDLE : S_RD;
            default: state_d = S_IDLE;
        endcase
        // A new line always restarts the scan, aborting whatever was in flight.
        if (line_start) state_d = (obj_count == '0) ? S_IDLE : S_RD;
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        fetch_start = (state_q == S_FETCH) && !line_start;
        draw_adv    = (state_q == S_DRAW) && !line_start && (blank || gap_q == '0);
        draw_fire   = draw_adv && !blank;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            vline_q  <= '0;
            entry_q  <= '0;
            col_q    <= '0;
            gap_q    <= '0;
            bits     <= '0;
            color    <= '0;
            prio     <= 1'b0;
            pos      <= '0;
            we       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= abort;
            we       <= draw_fire;
            // Free-running pacing counter; deliberately untouched by aborts.
            if (draw_fire)        gap_q <= GAP_RELOAD;
            else if (gap_q != '0) gap_q <= gap_q - GW'(1);
            if (line_start) begin
                idx_q   <= '0;
                cnt_q   <= obj_count;
                vline_q <= v_line;
            end else begin
                if (state_q == S_LAT) entry_q <= obj_data;
                if (state_q == S_CHK) col_q <= '0;
                if (draw_adv)         col_q <= col_q + 3'd1;
                if (state_q == S_NEXT) idx_q <= idx_inc;
            end
            if (draw_fire) begin
                bits  <= row_data;
                color <= entry_q.color;
                prio  <= entry_q.prio;
                pos   <= entry_q.x + {3'd0, col_q, 4'd0};
            end
        end
    end

    sprite_row_fetch #(.ROM_AW(ROM_AW)) u_fetch (
        .clk      (clk),
        .reset    (reset),
        .start    (fetch_start),
        .abort    (abort),
        .entry    (entry_q),
        .rel      (rel[6:0]),
        .col      (col_q),
        .rom_req  (rom_req),
        .rom_addr (rom_addr),
        .rom_ack  (rom_ack),
        .rom_data (rom_data),
        .done     (fetch_done),
        .row_data (row_data)
    );

endmodule

// File: tb/tb_sprite_line_sched.sv
// Scoreboard bench for sprite_line_sched: directed sprite lists, a ROM responder with
// programmable latency, and a monitor that checks every fetch address and draw pulse.
module tb_sprite_line_sched;

    localparam int DRAW_GAP = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [8:0]  v_line;
    logic [8:0]  obj_count;
    logic [7:0]  obj_addr;
    logic [63:0] obj_data;
    logic        rom_req;
    logic [19:0] rom_addr;
    logic        rom_ack;
    logic [63:0] rom_data;
    logic [63:0] bits;
    logic [6:0]  color;
    logic        prio;
    logic [9:0]  pos;
    logic        we;
    logic        busy;
    logic        overflow;

    sprite_line_sched dut (
        .clk(clk), .reset(reset), .line_start(line_start), .v_line(v_line),
        .obj_count(obj_count), .obj_addr(obj_addr), .obj_data(obj_data),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .bits(bits), .color(color), .prio(prio), .pos(pos), .we(we),
        .busy(busy), .overflow(overflow)
    );

    // ---------------- clock / reset / models ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] obj_mem [0:255];
    always @(posedge clk) obj_data <= obj_mem[obj_addr];

    int checks = 0;
    int failures = 0;
    int rom_delay = 0;
    logic [81:0] exp_q[$];
    logic [19:0] exp_addr_q[$];

    function automatic logic [63:0] rom_fn(input logic [19:0] a);
        if (a[19:4] == 16'h0700) return 64'd0;
        return {a[19:4] ^ 16'hBEEF, {12'h000, a[3:0]} ^ 16'h8001,
                a[19:4] + 16'h1357, 16'hF00F ^ {a[3:0], 12'h000}};
    endfunction

    function automatic logic [63:0] rev_planes(input logic [63:0] d);
        logic [63:0] r;
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 16; b++)
                r[p*16+b] = d[p*16+15-b];
        return r;
    endfunction

    function automatic logic [63:0] mk_entry(input int y, input int x, input int code,
                                             input int hc, input int wc, input int col,
                                             input int pr, input int fx, input int fy);
        logic [63:0] e;
        e = 64'd0;
        e[8:0]   = y[8:0];
        e[12:11] = hc[1:0];
        e[14:13] = wc[1:0];
        e[31:16] = code[15:0];
        e[38:32] = col[6:0];
        e[39]    = pr[0];
        e[40]    = fx[0];
        e[41]    = fy[0];
        e[57:48] = x[9:0];
        return e;
    endfunction

    // ROM: answers rom_delay cycles after it sees a request, even if the request was dropped.
    initial begin
        logic [19:0] a;
        rom_ack = 1'b0;
        rom_data = 64'd0;
        forever begin
            @(negedge clk);
            if (rom_req && !reset) begin
                a = rom_addr;
                repeat (rom_delay) @(negedge clk);
                rom_ack = 1'b1;
                rom_data = rom_fn(a);
                @(negedge clk);
                rom_ack = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [81:0] got, input logic [81:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic expect_draw(input int p, input int c, input int pr, input logic [63:0] b);
        logic [9:0] p10;
        logic [6:0] c7;
        p10 = p[9:0];
        c7 = c[6:0];
        exp_q.push_back({p10, c7, pr[0], b});
    endtask

    initial begin
        logic req_prev;
        int last_we;
        logic [81:0] e;
        logic [19:0] ea;
        req_prev = 1'b0;
        last_we = -1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (we) begin
                    if (last_we >= 0) check("we_spacing_ge_gap", 82'((cyc - last_we) >= DRAW_GAP), 82'd1);
                    last_we = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_we: got pos=%0d bits=%h required=no pulse", pos, bits);
                    end else begin
                        e = exp_q.pop_front();
                        check("draw", {pos, color, prio, bits}, e);
                    end
                end
                if (rom_req && !req_prev) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_fetch: got addr=%h required=no request", rom_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("rom_addr", 82'(rom_addr), 82'(ea));
                    end
                end
            end
            req_prev = rom_req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_line(input logic [8:0] vl, input logic [8:0] cnt);
        @(negedge clk);
        v_line = vl;
        obj_count = cnt;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int n = 0; n < budget && busy; n++) @(negedge clk);
        check(name, 82'(busy), 82'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        check(name, 82'(exp_q.size() + exp_addr_q.size()), 82'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1;
        line_start = 1'b0;
        v_line = '0;
        obj_count = '0;
        for (int i = 0; i < 256; i++) obj_mem[i] = 64'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_we", 82'(we), 82'd0);
        check("rst_rom_req", 82'(rom_req), 82'd0);
        check("rst_busy", 82'(busy), 82'd0);
        check("rst_overflow", 82'(overflow), 82'd0);
        check("rst_obj_addr", 82'(obj_addr), 82'd0);
        check("rst_pos", 82'(pos), 82'd0);
        check("rst_bits", 82'(bits), 82'd0);
        check("rst_rom_addr", 82'(rom_addr), 82'd0);

        // Single 16x16 sprite
        obj_mem[0] = mk_entry(100, 40, 'h0123, 0, 0, 'h15, 1, 0, 0);
        rom_delay = 2;
        exp_addr_q.push_back(20'h01235);
        expect_draw(40, 'h15, 1, rom_fn(20'h01235));
        start_line(9'd105, 9'd1);
        check("t1_busy_high", 82'(busy), 82'd1);
        wait_idle(200, "t1_busy_drop");
        check_drained("t1_drained");

        // 64-px wide, flipx, wrapping at x=1016
        obj_mem[0] = mk_entry(50, 1016, 'h0200, 0, 2, 'h2A, 0, 1, 0);
        rom_delay = 0;
        exp_addr_q.push_back(20'h02180);
        exp_addr_q.push_back(20'h02100);
        exp_addr_q.push_back(20'h02080);
        exp_addr_q.push_back(20'h02000);
        expect_draw(1016, 'h2A, 0, rev_planes(rom_fn(20'h02180)));
        expect_draw(8,    'h2A, 0, rev_planes(rom_fn(20'h02100)));
        expect_draw(24,   'h2A, 0, rev_planes(rom_fn(20'h02080)));
        expect_draw(40,   'h2A, 0, rev_planes(rom_fn(20'h02000)));
        start_line(9'd50, 9'd1);
        wait_idle(300, "t2_busy_drop");
        check_drained("t2_drained");

        // 32-px tall, flipy, rel=3 -> tile code+1, row 12
        obj_mem[0] = mk_entry(20, 100, 'h0300, 1, 0, 'h03, 0, 0, 1);
        rom_delay = 1;
        exp_addr_q.push_back(20'h0301C);
        expect_draw(100, 'h03, 0, rom_fn(20'h0301C));
        start_line(9'd23, 9'd1);
        wait_idle(200, "t3_busy_drop");
        check_drained("t3_drained");

        // y wrap: y=500 hits line 10 (rel 22); y=200 misses
        obj_mem[0] = mk_entry(500, 200, 'h0400, 1, 0, 'h11, 1, 0, 0);
        obj_mem[1] = mk_entry(200, 300, 'h0500, 0, 0, 'h22, 0, 0, 0);
        rom_delay = 3;
        exp_addr_q.push_back(20'h04016);
        expect_draw(200, 'h11, 1, rom_fn(20'h04016));
        start_line(9'd10, 9'd2);
        wait_idle(200, "t4_busy_drop");
        check_drained("t4_drained");

        // Blank row for sprite 0, real row for sprite 1
        obj_mem[0] = mk_entry(0, 10, 'h0700, 0, 0, 'h05, 0, 0, 0);
        obj_mem[1] = mk_entry(0, 60, 'h0800, 0, 0, 'h06, 1, 0, 0);
        rom_delay = 0;
        exp_addr_q.push_back(20'h07002);
        exp_addr_q.push_back(20'h08002);
`ifndef SPR_SKIP_BLANK_EN
        expect_draw(10, 'h05, 0, 64'd0);
`endif
        expect_draw(60, 'h06, 1, rom_fn(20'h08002));
        start_line(9'd2, 9'd2);
        wait_idle(200, "t6_busy_drop");
        check_drained("t6_drained");

        // 256 hitting sprites, slow ROM, abort during sprite 1's fetch
        for (int i = 0; i < 256; i++) obj_mem[i] = mk_entry(0, i, 'h0600 + i, 3, 0, i, 0, 0, 0);
        rom_delay = 20;
        exp_addr_q.push_back(20'h06005);
        exp_addr_q.push_back(20'h06015);
        expect_draw(0, 0, 0, rom_fn(20'h06005));
        start_line(9'd5, 9'd256);
        for (int n = 0; n < 300 && exp_addr_q.size() != 0; n++) @(negedge clk);
        check("t5_second_fetch_seen", 82'(exp_addr_q.size()), 82'd0);
        repeat (5) @(negedge clk);
        check("t5_obj_addr_before", 82'(obj_addr), 82'd1);
        v_line = 9'd300;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        check("t5_overflow", 82'(overflow), 82'd1);
        check("t5_rom_req_dropped", 82'(rom_req), 82'd0);
        check("t5_rescan_addr0", 82'(obj_addr), 82'd0);
        check("t5_busy_rescan", 82'(busy), 82'd1);
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        check("t5_overflow_one_cycle", 82'(overflow), 82'd0);
        wait_idle(3000, "t5_busy_drop");
        check_drained("t5_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_line_sched.md
Name: sprite_line_sched

Overview:
- Per-scanline sprite draw scheduler that feeds the double line buffer's write side (bits/color/prio/pos/we).
- On each line start it walks the sprite attribute list and selects sprites intersecting the line being prepared.
- For each 16-px column of a selected sprite it fetches one 64-bit planar row from sprite ROM over a req/ack handshake.
- It then issues one draw pulse, pacing pulses so the line buffer's 8-cycle, 16-pixel serialiser is never interrupted.

Parameters:
- OBJ_AW, 8, object RAM address width; list capacity is 2^OBJ_AW entries.
- ROM_AW, 20, sprite ROM word address width; 64-bit words, address = {tile[15:0], row[3:0]}.
- DRAW_GAP, 8, minimum cycles between successive we pulses; must be >= 8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse coincident with the line buffer toggle flip
- v_line  in  9  line being prepared; sampled on line_start
- obj_count  in  OBJ_AW+1  number of valid entries; sampled on line_start
- obj_addr  out  OBJ_AW  object RAM read address
- obj_data  in  64  object entry; valid exactly 1 cycle after obj_addr
- rom_req  out  1  ROM request, held until ack
- rom_addr  out  ROM_AW  ROM word address, stable while rom_req
- rom_ack  in  1  one-cycle pulse; rom_data valid in the same cycle
- rom_data  in  64  four 16-bit bitplanes, MSB = leftmost pixel
- bits  out  64  to line buffer
- color  out  7  to line buffer
- prio  out  1  to line buffer
- pos  out  10  to line buffer: left x of the 16-px column
- we  out  1  to line buffer; one-cycle draw pulse
- busy  out  1  high from line_start until list done or aborted
- overflow  out  1  one-cycle pulse when a line_start aborts an unfinished scan

Behaviour:
- Reset: all outputs 0; FSM in IDLE; gap counter 0.
- Entry fields (package): y[8:0]=d[8:0], hcode[1:0]=d[12:11], wcode[1:0]=d[14:13], code[15:0]=d[31:16], color[6:0]=d[38:32], prio=d[39], flipx=d[40], flipy=d[41], x[9:0]=d[57:48].
- Sprite size: height = 16<<hcode px; width = 1<<wcode columns.
- FSM states: IDLE, RD, LAT, CHK, FETCH, DRAW, NEXT.
- IDLE: on line_start, set idx=0 and busy=1.
  - If obj_count==0, go straight to done.
  - Otherwise go to RD.
- RD: obj_addr=idx. LAT: capture obj_data. CHK: rel = (v_line - y) mod 512, 9-bit.
  - Hit if rel < height; set col=0 and go to FETCH.
  - Miss: go to NEXT.
- FETCH:
  - tile = code + (c<<3) + rel[6:4], 16-bit wrap, where c = flipx ? width-1-col : col.
  - Row r = rel[3:0], inverted when flipy. With flipy, the row-tile term is also taken from (height-1-rel).
  - Assert rom_req with rom_addr={tile,r}.
  - On rom_ack, latch data; when flipx, bit-reverse each 16-bit plane.
- DRAW: wait until the gap counter is 0. Then, for exactly one cycle:
  - we=1; bits, color and prio driven from the latched data and entry.
  - pos = x + col*16, mod 1024.
  - Reload gap counter to DRAW_GAP-1.
  - Next: col+1 if col < width-1 (back to FETCH), else NEXT.
- NEXT: idx+1. When idx==obj_count, clear busy and go to IDLE; otherwise go to RD.
- Ordering: list order, index 0 first; later sprites overwrite earlier ones at the same pixels.
- Outputs hold their last values between we pulses.
- line_start when not IDLE:
  - Abort: overflow pulses 1 cycle.
  - Any outstanding rom_req is dropped the same cycle; a late ack is ignored.
  - Restart from idx 0 with the new v_line.
  - The gap counter keeps running, so pacing is preserved across the abort.
- Gap counter decrements every cycle regardless of state.
- reset mid-operation: immediate return to IDLE; rom_req low next cycle.

Optional Feature:
- SPR_SKIP_BLANK_EN defined: if latched rom_data==0, DRAW is skipped (no we, gap counter not reloaded) and the FSM advances as if drawn.
- Undefined: every fetched column produces a we pulse.

Decomposition:
- Package sprite_pkg:
  - obj_entry_t packed struct with the field layout above.
  - size decode function.
  - state enum.
  - DRAW_GAP default constant.
- Sub-module sprite_row_fetch: owns the FETCH handshake, tile/row address math and flipx plane reversal. Interface is start/done with entry, rel and col inputs.

Test Plan:
- Single 16x16 sprite, y=100, x=40, code=0x0123, v_line=105:
  - Expect rom_addr=0x01235.
  - Expect one we with pos=40 and bits equal to rom_data.
  - Expect busy to drop afterwards.
- Width 64 (wcode=2), flipx=1, x=1016, v_line=y:
  - Expect 4 fetches, tiles code+24, +16, +8, +0, each bit-reversed per plane.
  - Expect pos 1016, 8, 24, 40 (wrap at 1024).
  - Expect we pulses exactly 8+ cycles apart.
- Height 32 (hcode=1), flipy=1, rel=3:
  - Expect tile=code+1 and row=12.
- Sprite at y=500, height 32, v_line=10 (rel=22):
  - Expect a hit with row 6 of tile code+1.
  - A sprite at y=200 with the same v_line produces no fetch.
- 256 hitting sprites with rom_ack delayed 20 cycles, second line_start mid-scan:
  - Expect overflow pulse and rom_req dropped.
  - Expect rescan from obj_addr=0; a stray old ack produces no we.
- SPR_SKIP_BLANK_EN defined, rom_data=0 for sprite 0 and non-zero for sprite 1:
  - Expect exactly one we, for sprite 1.
  - Without the macro, expect two.
